// File: rtl/stream_reg_slice_pkg.sv
// Shared constants and helpers for the stream register slice chain.
package stream_reg_slice_pkg;

  localparam int unsigned MAX_STAGES = 16;

  // Beats held by a chain of skid stages: main plus skid per stage.
  function automatic int unsigned buffer_capacity(input int unsigned stages);
    return 2 * stages;
  endfunction

endpackage

// File: rtl/stream_skid_stage.sv
// One fully registered two-entry skid stage (main + skid register).
// Optional TLAST sideband: define STREAM_REG_SLICE_TLAST_EN.
module stream_skid_stage
  import stream_reg_slice_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 224
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY
`ifdef STREAM_REG_SLICE_TLAST_EN
  ,
  input  logic                   S_AXIS_TLAST,
  output logic                   M_AXIS_TLAST
`endif
);

  // Payload carried through main and skid together so TLAST shares the data timing.
  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
`ifdef STREAM_REG_SLICE_TLAST_EN
    logic                   last;
`endif
  } payload_t;

  payload_t in_pl;
  payload_t main_pl;
  payload_t skid_pl;
  logic     main_valid;
  logic     skid_valid;
  logic     in_ready;
  logic     main_valid_nxt;
  logic     skid_valid_nxt;
  logic     accept;
  logic     main_load;

  // Bundle the incoming beat.
  always_comb begin
    in_pl      = '0;
    in_pl.data = S_AXIS_TDATA;
`ifdef STREAM_REG_SLICE_TLAST_EN
    in_pl.last = S_AXIS_TLAST;
`endif
  end

  assign accept    = S_AXIS_TVALID && in_ready;
  // Main can take a new beat when it is empty or being drained this edge.
  assign main_load = !main_valid || M_AXIS_TREADY;

  // Occupancy update; skid only fills when main is full and stalled.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    if (skid_valid) begin
      // in_ready is low here, so no new beat can arrive; skid refills main on drain.
      if (M_AXIS_TREADY) begin
        skid_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      if (main_load) begin
        main_valid_nxt = 1'b1;
      end else begin
        skid_valid_nxt = 1'b1;
      end
    end else if (M_AXIS_TREADY) begin
      main_valid_nxt = 1'b0;
    end
  end

  // Valid bits and registered ready; ready held low throughout reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
    end
  end

  // Payload registers are left unreset; they are only observed behind a valid bit.
  always_ff @(posedge CLK) begin
    if (skid_valid) begin
      if (M_AXIS_TREADY) begin
        main_pl <= skid_pl;
      end
    end else if (accept) begin
      if (main_load) begin
        main_pl <= in_pl;
      end else begin
        skid_pl <= in_pl;
      end
    end
  end

  assign S_AXIS_TREADY = in_ready;
  assign M_AXIS_TVALID = main_valid;
  assign M_AXIS_TDATA  = main_pl.data;
`ifdef STREAM_REG_SLICE_TLAST_EN
  assign M_AXIS_TLAST  = main_pl.last;
`endif

endmodule

// File: rtl/stream_reg_slice.sv
// AXI4-Stream register slice: STAGES skid stages in series, or a wire bypass
// when STAGES is 0. Optional TLAST and packet counter: define STREAM_REG_SLICE_TLAST_EN.
module stream_reg_slice
  import stream_reg_slice_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 224,
  parameter int unsigned STAGES      = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY
`ifdef STREAM_REG_SLICE_TLAST_EN
  ,
  input  logic                   S_AXIS_TLAST,
  output logic                   M_AXIS_TLAST,
  output logic [31:0]            PKT_COUNT
`endif
);

  if (buffer_capacity(STAGES) > buffer_capacity(MAX_STAGES) || TDATA_WIDTH < 1) begin : g_param_check
    $error("stream_reg_slice: STAGES must be 0..16 and TDATA_WIDTH at least 1");
  end

  if (STAGES == 0) begin : g_bypass
    assign M_AXIS_TDATA  = S_AXIS_TDATA;
    assign M_AXIS_TVALID = S_AXIS_TVALID;
    assign S_AXIS_TREADY = M_AXIS_TREADY;
`ifdef STREAM_REG_SLICE_TLAST_EN
    assign M_AXIS_TLAST  = S_AXIS_TLAST;
`endif
  end else begin : g_chain
    // Index i is the boundary in front of stage i; index STAGES is the output.
    logic [TDATA_WIDTH-1:0] data  [STAGES+1];
    logic                   valid [STAGES+1];
    logic                   ready [STAGES+1];
`ifdef STREAM_REG_SLICE_TLAST_EN
    logic                   last  [STAGES+1];

    assign last[0]      = S_AXIS_TLAST;
    assign M_AXIS_TLAST = last[STAGES];
`endif

    assign data[0]       = S_AXIS_TDATA;
    assign valid[0]      = S_AXIS_TVALID;
    assign S_AXIS_TREADY = ready[0];
    assign M_AXIS_TDATA  = data[STAGES];
    assign M_AXIS_TVALID = valid[STAGES];
    assign ready[STAGES] = M_AXIS_TREADY;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      stream_skid_stage #(
        .TDATA_WIDTH(TDATA_WIDTH)
      ) u_stage (
        .CLK           (CLK),
        .RST           (RST),
        .S_AXIS_TDATA  (data[i]),
        .S_AXIS_TVALID (valid[i]),
        .S_AXIS_TREADY (ready[i]),
        .M_AXIS_TDATA  (data[i+1]),
        .M_AXIS_TVALID (valid[i+1]),
        .M_AXIS_TREADY (ready[i+1])
`ifdef STREAM_REG_SLICE_TLAST_EN
        ,
        .S_AXIS_TLAST  (last[i]),
        .M_AXIS_TLAST  (last[i+1])
`endif
      );
    end
  end

`ifdef STREAM_REG_SLICE_TLAST_EN
  // Count completed packets leaving the slice; wraps naturally at 32 bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PKT_COUNT <= '0;
    end else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
      PKT_COUNT <= PKT_COUNT + 32'd1;
    end
  end
`endif

  // Upstream must hold TVALID until its beat is taken.
  a_valid_hold: assert property (@(posedge CLK) disable iff (RST)
    (S_AXIS_TVALID && !S_AXIS_TREADY) |=> S_AXIS_TVALID);

endmodule

// File: tb/tb_stream_reg_slice.sv
// Directed bench for stream_reg_slice: STAGES=2 (224-bit), STAGES=3 and STAGES=0.
// TLAST checks are compiled in when STREAM_REG_SLICE_TLAST_EN is defined.
module tb_stream_reg_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [223:0] s2_sd, s2_md;
  logic         s2_sv, s2_sr, s2_mv, s2_mr;
  logic [15:0]  s3_sd, s3_md;
  logic         s3_sv, s3_sr, s3_mv, s3_mr;
  logic [7:0]   s0_sd, s0_md;
  logic         s0_sv, s0_sr, s0_mv, s0_mr;
`ifdef STREAM_REG_SLICE_TLAST_EN
  logic         s2_sl, s2_ml, s3_sl, s3_ml, s0_sl, s0_ml;
  logic [31:0]  s2_cnt, s3_cnt, s0_cnt;
`endif

  stream_reg_slice #(.TDATA_WIDTH(224), .STAGES(2)) u_s2 (
    .CLK(clk), .RST(rst),
    .S_AXIS_TDATA(s2_sd), .S_AXIS_TVALID(s2_sv), .S_AXIS_TREADY(s2_sr),
    .M_AXIS_TDATA(s2_md), .M_AXIS_TVALID(s2_mv), .M_AXIS_TREADY(s2_mr)
`ifdef STREAM_REG_SLICE_TLAST_EN
    , .S_AXIS_TLAST(s2_sl), .M_AXIS_TLAST(s2_ml), .PKT_COUNT(s2_cnt)
`endif
  );

  stream_reg_slice #(.TDATA_WIDTH(16), .STAGES(3)) u_s3 (
    .CLK(clk), .RST(rst),
    .S_AXIS_TDATA(s3_sd), .S_AXIS_TVALID(s3_sv), .S_AXIS_TREADY(s3_sr),
    .M_AXIS_TDATA(s3_md), .M_AXIS_TVALID(s3_mv), .M_AXIS_TREADY(s3_mr)
`ifdef STREAM_REG_SLICE_TLAST_EN
    , .S_AXIS_TLAST(s3_sl), .M_AXIS_TLAST(s3_ml), .PKT_COUNT(s3_cnt)
`endif
  );

  stream_reg_slice #(.TDATA_WIDTH(8), .STAGES(0)) u_s0 (
    .CLK(clk), .RST(rst),
    .S_AXIS_TDATA(s0_sd), .S_AXIS_TVALID(s0_sv), .S_AXIS_TREADY(s0_sr),
    .M_AXIS_TDATA(s0_md), .M_AXIS_TVALID(s0_mv), .M_AXIS_TREADY(s0_mr)
`ifdef STREAM_REG_SLICE_TLAST_EN
    , .S_AXIS_TLAST(s0_sl), .M_AXIS_TLAST(s0_ml), .PKT_COUNT(s0_cnt)
`endif
  );

  int unsigned n_tests, n_fail;
  int unsigned beat, exp_n, cyc, acc, sent, got, mcnt;
  int unsigned first_in, first_out, last_out;
  bit          seen_in, seen_out, pend, stall, seen;
  logic        sf, mf;
  logic [223:0] md, hold_d, rnd;
  logic [15:0]  md16;
  logic [223:0] sb [$];

  task automatic check(input string tag, input logic [255:0] got_v, input logic [255:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Called just after a negedge with inputs set; samples the handshakes the next
  // posedge will see and returns at the following negedge.
  task automatic tick2(output logic s_fire, output logic m_fire, output logic [223:0] m_data);
    #1;
    s_fire = s2_sv && s2_sr;
    m_fire = s2_mv && s2_mr;
    m_data = s2_md;
    @(negedge clk);
  endtask

  task automatic tick3(output logic s_fire, output logic m_fire, output logic [15:0] m_data);
    #1;
    s_fire = s3_sv && s3_sr;
    m_fire = s3_mv && s3_mr;
    m_data = s3_md;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    s2_sd = '0; s2_sv = 1'b0; s2_mr = 1'b0;
    s3_sd = '0; s3_sv = 1'b0; s3_mr = 1'b0;
    s0_sd = '0; s0_sv = 1'b0; s0_mr = 1'b0;
`ifdef STREAM_REG_SLICE_TLAST_EN
    s2_sl = 1'b0; s3_sl = 1'b0; s0_sl = 1'b0;
`endif

    // ---- reset state and release ----
    repeat (3) @(negedge clk);
    check("rst_s2_ready", s2_sr, 0);
    check("rst_s2_valid", s2_mv, 0);
    check("rst_s3_ready", s3_sr, 0);
    check("rst_s3_valid", s3_mv, 0);
    rst = 1'b0;
    #1;
    check("rel_s2_ready_before_edge", s2_sr, 0);
    @(negedge clk);
    check("rel_s2_ready", s2_sr, 1);
    check("rel_s3_ready", s3_sr, 1);

    // ---- STAGES=2 streaming 0x01..0x10, downstream always ready ----
    s2_mr = 1'b1;
    beat = 1; exp_n = 1; cyc = 0; seen_in = 0; seen_out = 0;
    first_in = 0; first_out = 0; last_out = 0;
    while (exp_n <= 16 && cyc < 100) begin
      s2_sv = (beat <= 16);
      s2_sd = 224'(beat);
      tick2(sf, mf, md);
      if (sf) begin
        if (!seen_in) first_in = cyc;
        seen_in = 1;
        beat++;
      end
      if (mf) begin
        check("t1_data", md, 256'(exp_n));
        if (!seen_out) first_out = cyc;
        seen_out = 1;
        last_out = cyc;
        exp_n++;
      end
      cyc++;
    end
    s2_sv = 1'b0;
    check("t1_count", exp_n - 1, 16);
    check("t1_latency", first_out - first_in, 2);
    check("t1_no_gaps", last_out - first_out, 15);

    // ---- STAGES=3 backpressure fill then drain ----
    s3_mr = 1'b0; beat = 1; acc = 0;
    for (int i = 0; i < 20; i++) begin
      s3_sv = 1'b1;
      s3_sd = 16'(beat);
      tick3(sf, mf, md16);
      if (sf) begin
        beat++;
        acc++;
      end
    end
    check("t2_fill_count", acc, 6);
    check("t2_ready_low", s3_sr, 0);
    check("t2_head_valid", s3_mv, 1);
    check("t2_head_data", s3_md, 1);
    s3_mr = 1'b1; exp_n = 1; cyc = 0;
    while (exp_n <= 20 && cyc < 200) begin
      s3_sv = (beat <= 20);
      s3_sd = 16'(beat);
      tick3(sf, mf, md16);
      if (sf) beat++;
      if (mf) begin
        check("t2_order", md16, 256'(exp_n));
        exp_n++;
      end
      cyc++;
    end
    s3_sv = 1'b0;
    check("t2_total", exp_n - 1, 20);

    // ---- STAGES=2 random stalls with scoreboard ----
    sent = 0; got = 0; cyc = 0; pend = 0; stall = 0; hold_d = '0;
    while (got < 10000 && cyc < 60000) begin
      if (!pend) begin
        if (sent < 10000 && $urandom_range(1) == 1) begin
          for (int k = 0; k < 7; k++) rnd[k*32 +: 32] = $urandom;
          s2_sv = 1'b1;
          s2_sd = rnd;
        end else begin
          s2_sv = 1'b0;
        end
      end
      s2_mr = ($urandom_range(1) == 1);
      #1;
      if (stall) begin
        check("t3_hold_valid", s2_mv, 1);
        check("t3_hold_data", s2_md, hold_d);
      end
      stall  = s2_mv && !s2_mr;
      hold_d = s2_md;
      sf = s2_sv && s2_sr;
      mf = s2_mv && s2_mr;
      md = s2_md;
      @(negedge clk);
      if (sf) begin
        sb.push_back(s2_sd);
        sent++;
        pend = 0;
      end else begin
        pend = s2_sv;
      end
      if (mf) begin
        check("t3_sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) check("t3_data", md, sb.pop_front());
        got++;
      end
      cyc++;
    end
    s2_sv = 1'b0;
    check("t3_got", got, 10000);
    check("t3_sb_empty", sb.size(), 0);

    // ---- mid-stream asynchronous reset with 3 beats buffered ----
    s2_mr = 1'b0; beat = 0; cyc = 0;
    while (beat < 3 && cyc < 20) begin
      s2_sv = 1'b1;
      s2_sd = 224'(17 * (beat + 1));
      tick2(sf, mf, md);
      if (sf) beat++;
      cyc++;
    end
    s2_sv = 1'b0;
    check("t4_buffered", beat, 3);
    check("t4_buffered_valid", s2_mv, 1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_valid_drop", s2_mv, 0);
    check("t4_rst_ready", s2_sr, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    s2_mr = 1'b1; mcnt = 0;
    repeat (8) begin
      tick2(sf, mf, md);
      if (mf) mcnt++;
    end
    check("t4_no_stale", mcnt, 0);
    s2_sv = 1'b1; s2_sd = 224'hAB; seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      tick2(sf, mf, md);
      if (sf) s2_sv = 1'b0;
      if (mf) begin
        check("t4_post_data", md, 256'hAB);
        seen = 1;
      end
      cyc++;
    end
    s2_sv = 1'b0;
    check("t4_post_seen", seen, 1);

    // ---- STAGES=0 bypass: zero-delay wires ----
    s0_sd = 8'h5A; s0_sv = 1'b1; s0_mr = 1'b0;
    #1;
    check("t5_data_a", s0_md, 8'h5A);
    check("t5_valid_a", s0_mv, 1);
    check("t5_ready_a", s0_sr, 0);
    s0_sd = 8'hA5; s0_sv = 1'b0; s0_mr = 1'b1;
    #1;
    check("t5_data_b", s0_md, 8'hA5);
    check("t5_valid_b", s0_mv, 0);
    check("t5_ready_b", s0_sr, 1);
    s0_sd = 8'hFF; s0_sv = 1'b1; s0_mr = 1'b1;
    #1;
    check("t5_data_c", s0_md, 8'hFF);
    check("t5_valid_c", s0_mv, 1);
    check("t5_ready_c", s0_sr, 1);
    s0_sd = 8'h00; s0_sv = 1'b0; s0_mr = 1'b0;
    #1;
    check("t5_data_d", s0_md, 8'h00);
    check("t5_ready_d", s0_sr, 0);
    @(negedge clk);

`ifdef STREAM_REG_SLICE_TLAST_EN
    // ---- packets of length 1, 4, 7: TLAST on output beats 1, 5, 12 ----
    check("t6_cnt_start", s2_cnt, 0);
    s2_mr = 1'b1; beat = 1; exp_n = 1; cyc = 0;
    while (exp_n <= 12 && cyc < 100) begin
      s2_sv = (beat <= 12);
      s2_sd = 224'(beat);
      s2_sl = (beat == 1 || beat == 5 || beat == 12);
      #1;
      sf = s2_sv && s2_sr;
      mf = s2_mv && s2_mr;
      if (mf) begin
        check("t6_data", s2_md, 256'(exp_n));
        check("t6_last", s2_ml, (exp_n == 1 || exp_n == 5 || exp_n == 12));
        exp_n++;
      end
      @(negedge clk);
      if (sf) beat++;
      cyc++;
    end
    s2_sv = 1'b0; s2_sl = 1'b0;
    check("t6_beats", exp_n - 1, 12);
    check("t6_pkt_count", s2_cnt, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
